// File: rtl/cam_cfg_pkg.sv
// cam_cfg_pkg: shared definitions for the camera configuration sequencer.
//   END_MARK   - table word that terminates configuration
//   DELAY_MARK - table word that inserts a timed delay (only honoured when
//                CAM_CFG_DELAY_EN is defined)
//   cfg_state_e - 3-bit sequencer state encoding
package cam_cfg_pkg;

  localparam logic [15:0] END_MARK   = 16'hFFFF;
  localparam logic [15:0] DELAY_MARK = 16'hFFF0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_WAIT_ROM = 3'd2,
    ST_DECODE   = 3'd3,
    ST_SEND     = 3'd4,
    ST_DELAY    = 3'd5,
    ST_DONE     = 3'd6,
    ST_FAULT    = 3'd7
  } cfg_state_e;

  function automatic logic is_end_mark(input logic [15:0] w);
    return w == END_MARK;
  endfunction

endpackage

// File: rtl/cam_cfg_timer.sv
// cam_cfg_timer: loadable saturating down-counter with a done flag.
// Shared by the SEND timeout and the DELAY wait.
//   clk, reset  - clock, synchronous active-high reset
//   clr         - synchronous clear to zero
//   load        - load load_val (wins over en)
//   load_val    - value loaded on load
//   en          - decrement by one; holds at zero, never wraps
//   done        - counter is zero
module cam_cfg_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr)            cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (en && cnt != '0)    cnt <= cnt - W'(1);
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/cam_cfg_sequencer.sv
// cam_cfg_sequencer: walks a registered {reg,value} table ROM and issues
// one SCCB write per entry, in table order, after reset.
//   clk, reset      - clock, synchronous active-high reset
//   resend          - pulse: restart configuration from entry 0
//   rom_addr        - table address (ROM data valid one cycle later)
//   rom_data        - {reg[15:8], value[7:0]}
//   sccb_send       - write request, held until sccb_taken
//   sccb_taken      - SCCB master accepted id/reg/value
//   sccb_id         - constant SLAVE_ID
//   sccb_reg/value  - write payload, stable while sccb_send is high
//   configured      - table finished (end marker or last address)
//   fault           - SCCB master never took a write within TIMEOUT cycles
// Build option: CAM_CFG_DELAY_EN enables 16'hFFF0 as a delay marker of
// DELAY_TICKS cycles; without it that word is written like any other.
module cam_cfg_sequencer import cam_cfg_pkg::*; #(
  parameter logic [7:0] SLAVE_ID    = 8'h42,
  parameter int         ADDR_W      = 8,
  parameter int         DELAY_TICKS = 250000,
  parameter int         TIMEOUT     = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              resend,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              sccb_send,
  input  logic              sccb_taken,
  output logic [7:0]        sccb_id,
  output logic [7:0]        sccb_reg,
  output logic [7:0]        sccb_value,
  output logic              configured,
  output logic              fault
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
`ifdef CAM_CFG_DELAY_EN
  localparam int TW = (TO_W > 32) ? TO_W : 32;
  // The marker's own FETCH/WAIT_ROM/DECODE cycles count toward the delay,
  // so the dwell in DELAY is DELAY_TICKS-3 cycles (load+1 with done at 0).
  localparam logic [TW-1:0] DLY_LOAD = (DELAY_TICKS > 4) ? TW'(DELAY_TICKS - 4) : '0;
`else
  localparam int TW = TO_W;
`endif
  // done at zero after load+1 SEND cycles -> FAULT after TIMEOUT cycles of send
  localparam logic [TW-1:0] TO_LOAD = (TIMEOUT > 1) ? TW'(TIMEOUT - 1) : '0;

  cfg_state_e        state, nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        reg_q, val_q;
  logic              restart, last_entry;
  logic              tmr_load, tmr_en, tmr_done;
  logic [TW-1:0]     tmr_val;

  assign restart    = resend && (state != ST_IDLE);
  assign last_entry = (addr_q == {ADDR_W{1'b1}});

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= nxt;
  end

  // next state
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:     nxt = ST_FETCH;
      ST_FETCH:    nxt = ST_WAIT_ROM;
      ST_WAIT_ROM: nxt = ST_DECODE;
      ST_DECODE: begin
        if (is_end_mark(rom_data))       nxt = ST_DONE;
`ifdef CAM_CFG_DELAY_EN
        else if (rom_data == DELAY_MARK) nxt = ST_DELAY;
`endif
        else                             nxt = ST_SEND;
      end
      ST_SEND: begin
        // an accepted write beats a same-cycle timeout
        if (sccb_taken)    nxt = last_entry ? ST_DONE : ST_FETCH;
        else if (tmr_done) nxt = ST_FAULT;
      end
`ifdef CAM_CFG_DELAY_EN
      ST_DELAY: if (tmr_done) nxt = last_entry ? ST_DONE : ST_FETCH;
`endif
      ST_DONE:     nxt = ST_DONE;
      ST_FAULT:    nxt = ST_FAULT;
      default:     nxt = ST_IDLE;
    endcase
    if (restart) nxt = ST_FETCH;
  end

  // outputs and timer control
  always_comb begin
    sccb_send  = (state == ST_SEND);
    configured = (state == ST_DONE);
    fault      = (state == ST_FAULT);
    tmr_load   = (state == ST_DECODE) && (nxt == ST_SEND);
    tmr_val    = TO_LOAD;
    tmr_en     = (state == ST_SEND);
`ifdef CAM_CFG_DELAY_EN
    if (state == ST_DECODE && nxt == ST_DELAY) begin
      tmr_load = 1'b1;
      tmr_val  = DLY_LOAD;
    end
    if (state == ST_DELAY) tmr_en = 1'b1;
`endif
  end

  // table address and latched payload
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      reg_q  <= '0;
      val_q  <= '0;
    end else if (restart) begin
      addr_q <= '0;
    end else begin
      if (state == ST_DECODE && nxt == ST_SEND) {reg_q, val_q} <= rom_data;
      // advancing to FETCH from SEND/DELAY means the entry finished and was not last
      if (nxt == ST_FETCH && (state == ST_SEND || state == ST_DELAY))
        addr_q <= addr_q + ADDR_W'(1);
    end
  end

  cam_cfg_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (restart),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .done     (tmr_done)
  );

  assign rom_addr   = addr_q;
  assign sccb_id    = SLAVE_ID;
  assign sccb_reg   = reg_q;
  assign sccb_value = val_q;

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// Directed bench for cam_cfg_sequencer with TIMEOUT=50, DELAY_TICKS=100.
// Expectations for the 16'hFFF0 entry follow CAM_CFG_DELAY_EN.
module tb_cam_cfg_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        resend = 1'b0;
  logic        sccb_taken = 1'b0;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        sccb_send;
  logic [7:0]  sccb_id, sccb_reg, sccb_value;
  logic        configured, fault;

  logic [15:0] rom [0:255];
  int          cyc = 0;
  int          nvec = 0;
  int          nerr = 0;

  cam_cfg_sequencer #(
    .SLAVE_ID(8'h42), .ADDR_W(8), .DELAY_TICKS(100), .TIMEOUT(50)
  ) dut (
    .clk(clk), .reset(reset), .resend(resend),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .sccb_send(sccb_send), .sccb_taken(sccb_taken),
    .sccb_id(sccb_id), .sccb_reg(sccb_reg), .sccb_value(sccb_value),
    .configured(configured), .fault(fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_resend();
    resend = 1'b1;
    @(negedge clk);
    resend = 1'b0;
  endtask

  task automatic wait_send(input string tag, output int scyc);
    int k = 0;
    while (!sccb_send && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "/send_seen"}, 32'(sccb_send), 1);
    scyc = cyc;
  endtask

  // wait for a write, check payload, hold it `hold` cycles, then pulse taken
  task automatic xact(input string tag, input logic [7:0] er, input logic [7:0] ev,
                      input int hold, output int scyc, output int tcyc);
    wait_send(tag, scyc);
    chk({tag, "/reg"}, 32'(sccb_reg), 32'(er));
    chk({tag, "/val"}, 32'(sccb_value), 32'(ev));
    repeat (hold) begin
      @(negedge clk);
      chk({tag, "/hold_send"}, 32'(sccb_send), 1);
      chk({tag, "/hold_reg"}, 32'(sccb_reg), 32'(er));
      chk({tag, "/hold_val"}, 32'(sccb_value), 32'(ev));
    end
    sccb_taken = 1'b1;
    tcyc = cyc;
    @(negedge clk);
    sccb_taken = 1'b0;
  endtask

  initial begin
    int s, t, t1;
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    rom[0] = 16'h1280; rom[1] = 16'h1204; rom[2] = 16'hFFFF;

    // reset values
    step(3);
    chk("rst_addr", 32'(rom_addr), 0);
    chk("rst_send", 32'(sccb_send), 0);
    chk("rst_reg", 32'(sccb_reg), 0);
    chk("rst_val", 32'(sccb_value), 0);
    chk("rst_cfg", 32'(configured), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_id", 32'(sccb_id), 32'h42);
    reset = 1'b0;

    // basic 3-entry table
    xact("t1_w0", 8'h12, 8'h80, 5, s, t1);
    xact("t1_w1", 8'h12, 8'h04, 5, s, t);
    chk("t1_gap", 32'(s - t1), 4);
    step(3);
    chk("t1_cfg", 32'(configured), 1);
    chk("t1_addr", 32'(rom_addr), 2);
    chk("t1_send_off", 32'(sccb_send), 0);
    step(4);
    chk("t1_done_hold", 32'(configured), 1);

    // resend from DONE
    pulse_resend();
    chk("rs_done_cfg", 32'(configured), 0);
    chk("rs_done_addr", 32'(rom_addr), 0);
    xact("rs_done_w0", 8'h12, 8'h80, 5, s, t1);
    xact("rs_done_w1", 8'h12, 8'h04, 5, s, t);
    step(3);
    chk("rs_done_cfg2", 32'(configured), 1);

    // delay marker
    rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1100; rom[3] = 16'hFFFF;
    pulse_resend();
    xact("dly_w0", 8'h12, 8'h80, 5, s, t1);
`ifdef CAM_CFG_DELAY_EN
    xact("dly_w1", 8'h11, 8'h00, 5, s, t);
    chk("dly_gap", 32'(s - t1), 104);
`else
    xact("dly_w1", 8'hFF, 8'hF0, 5, s, t);
    chk("dly_gap", 32'(s - t1), 4);
    xact("dly_w2", 8'h11, 8'h00, 5, s, t);
`endif
    step(3);
    chk("dly_cfg", 32'(configured), 1);

    // reset in the middle of the second entry (DELAY when enabled)
    pulse_resend();
    xact("mid_w0", 8'h12, 8'h80, 5, s, t);
    step(20);
    reset = 1'b1;
    step(1);
    chk("mid_rst_addr", 32'(rom_addr), 0);
    chk("mid_rst_send", 32'(sccb_send), 0);
    chk("mid_rst_reg", 32'(sccb_reg), 0);
    chk("mid_rst_val", 32'(sccb_value), 0);
    chk("mid_rst_cfg", 32'(configured), 0);
    chk("mid_rst_fault", 32'(fault), 0);
    reset = 1'b0;
    xact("mid_restart_w0", 8'h12, 8'h80, 5, s, t);

    // taken never arrives -> FAULT after 50 cycles of send
    rom[0] = 16'h1280; rom[1] = 16'h1204; rom[2] = 16'hFFFF; rom[3] = 16'hFFFF;
    pulse_resend();
    wait_send("to", s);
    step(49);
    chk("to_pre_fault", 32'(fault), 0);
    chk("to_pre_send", 32'(sccb_send), 1);
    step(1);
    chk("to_fault", 32'(fault), 1);
    chk("to_send_off", 32'(sccb_send), 0);
    chk("to_cfg", 32'(configured), 0);
    step(5);
    chk("to_fault_hold", 32'(fault), 1);

    // resend from FAULT
    pulse_resend();
    chk("rs_fault_fault", 32'(fault), 0);
    chk("rs_fault_addr", 32'(rom_addr), 0);
    xact("rs_fault_w0", 8'h12, 8'h80, 5, s, t);

    // resend coincident with taken on the second entry
    wait_send("coin", s);
    chk("coin_reg", 32'(sccb_reg), 32'h12);
    chk("coin_val", 32'(sccb_value), 32'h04);
    step(2);
    sccb_taken = 1'b1;
    resend = 1'b1;
    step(1);
    sccb_taken = 1'b0;
    resend = 1'b0;
    chk("coin_addr", 32'(rom_addr), 0);
    chk("coin_send_off", 32'(sccb_send), 0);
    xact("coin_w0", 8'h12, 8'h80, 5, s, t);
    xact("coin_w1", 8'h12, 8'h04, 5, s, t);
    step(3);
    chk("coin_cfg", 32'(configured), 1);

    // full table without end marker: last address processed, then DONE
    for (int i = 0; i < 256; i++) rom[i] = {8'(i), ~8'(i)};
    pulse_resend();
    for (int i = 0; i < 256; i++) xact("wrap", 8'(i), ~8'(i), 0, s, t);
    step(3);
    chk("wrap_cfg", 32'(configured), 1);
    chk("wrap_addr", 32'(rom_addr), 32'hFF);
    step(3);
    chk("wrap_no_send", 32'(sccb_send), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
